// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage of the miniRV core.
// Forwards EX/MEM/WB results into the ID operands, detects load-use hazards
// (stalling PC and IF/ID while inserting a bubble), squashes wrong-path work
// on an EX redirect, and registers the EX-stage bundle.
// Optional: define HAZARD_PERF_EN to add the perf_stall_cnt / perf_flush_cnt
// hazard counters.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst_n,
  input  logic            hold,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rD1,
  input  logic [XLEN-1:0] id_rD2,
  input  logic [XLEN-1:0] id_ext,
  input  logic [RA_W-1:0] id_rR1,
  input  logic [RA_W-1:0] id_rR2,
  input  logic [RA_W-1:0] id_wR,
  input  logic            id_rR1_read,
  input  logic            id_rR2_read,
  input  logic            id_is_load,
  input  logic            id_is_B,
  input  logic            id_is_jal,
  input  logic            id_is_jalr,
  input  logic            id_ram_we,
  input  logic            id_alub_sel,
  input  logic            id_rf_we,
  input  logic [2:0]      id_alu_op,
  input  logic [1:0]      id_rf_wsel,
  input  logic [2:0]      id_br_op,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_fwd_wD,
  input  logic            mem_rf_we,
  input  logic [RA_W-1:0] mem_wR,
  input  logic [XLEN-1:0] mem_wD,
  input  logic            wb_rf_we,
  input  logic [RA_W-1:0] wb_wR,
  input  logic [XLEN-1:0] wb_wD,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            flush_ifid,
`ifdef HAZARD_PERF_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rD1,
  output logic [XLEN-1:0] ex_rD2,
  output logic [XLEN-1:0] ex_ext,
  output logic [RA_W-1:0] ex_wR,
  output logic            ex_is_load,
  output logic            ex_is_B,
  output logic            ex_is_jal,
  output logic            ex_is_jalr,
  output logic            ex_ram_we,
  output logic [2:0]      ex_alu_op,
  output logic            ex_alub_sel,
  output logic            ex_rf_we,
  output logic [1:0]      ex_rf_wsel,
  output logic [2:0]      ex_br_op
);

  logic [XLEN-1:0] fwd_rd1;
  logic [XLEN-1:0] fwd_rd2;
  logic            lu;
  logic            bubble_sel;

  // Operand 1 bypass: youngest producer wins; x0 and unused sources pass through.
  // A load in EX has no data yet, so it is never a bypass source.
  always_comb begin
    fwd_rd1 = id_rD1;
    if (id_rR1_read && id_rR1 != '0) begin
      if (ex_valid && ex_rf_we && !ex_is_load && ex_wR == id_rR1)
        fwd_rd1 = ex_fwd_wD;
      else if (mem_rf_we && mem_wR == id_rR1)
        fwd_rd1 = mem_wD;
      else if (wb_rf_we && wb_wR == id_rR1)
        fwd_rd1 = wb_wD;
    end
  end

  // Operand 2 bypass, same priority as operand 1.
  always_comb begin
    fwd_rd2 = id_rD2;
    if (id_rR2_read && id_rR2 != '0) begin
      if (ex_valid && ex_rf_we && !ex_is_load && ex_wR == id_rR2)
        fwd_rd2 = ex_fwd_wD;
      else if (mem_rf_we && mem_wR == id_rR2)
        fwd_rd2 = mem_wD;
      else if (wb_rf_we && wb_wR == id_rR2)
        fwd_rd2 = wb_wD;
    end
  end

  // Load-use detection and the resulting front-end stall/flush controls.
  always_comb begin
    lu = id_valid && ex_valid && ex_is_load && ex_rf_we && (ex_wR != '0) &&
         ((id_rR1_read && id_rR1 == ex_wR) || (id_rR2_read && id_rR2 == ex_wR));
    stall_pc   = lu && !ex_redirect && !hold;
    stall_ifid = stall_pc;
    flush_ifid = ex_redirect && !hold;
    bubble_sel = ex_redirect || lu || !id_valid;
  end

  // EX bundle register: hold freezes, otherwise bubble or capture the ID bundle.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n || (!hold && bubble_sel)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rD1      <= '0;
      ex_rD2      <= '0;
      ex_ext      <= '0;
      ex_wR       <= '0;
      ex_is_load  <= 1'b0;
      ex_is_B     <= 1'b0;
      ex_is_jal   <= 1'b0;
      ex_is_jalr  <= 1'b0;
      ex_ram_we   <= 1'b0;
      ex_alu_op   <= 3'b000;
      ex_alub_sel <= 1'b0;
      ex_rf_we    <= 1'b0;
      ex_rf_wsel  <= 2'b00;
      ex_br_op    <= 3'b111;
    end else if (!hold) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rD1      <= fwd_rd1;
      ex_rD2      <= fwd_rd2;
      ex_ext      <= id_ext;
      ex_wR       <= id_wR;
      ex_is_load  <= id_is_load;
      ex_is_B     <= id_is_B;
      ex_is_jal   <= id_is_jal;
      ex_is_jalr  <= id_is_jalr;
      ex_ram_we   <= id_ram_we;
      ex_alu_op   <= id_alu_op;
      ex_alub_sel <= id_alub_sel;
      ex_rf_we    <= id_rf_we;
      ex_rf_wsel  <= id_rf_wsel;
      ex_br_op    <= id_br_op;
    end
  end

`ifdef HAZARD_PERF_EN
  // Hazard counters: one tick per inserted redirect or load-use bubble, frozen by hold.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (!hold) begin
      if (ex_redirect)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      else if (lu)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural model of the EX bundle,
// directed scenarios with literal expectations, then randomized traffic.
// Define HAZARD_PERF_EN to also check the hazard counters.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [4:0]  wr;
    logic        is_load;
    logic        is_b;
    logic        is_jal;
    logic        is_jalr;
    logic        ram_we;
    logic [2:0]  alu_op;
    logic        alub_sel;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic [2:0]  br_op;
  } bundle_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        hold, id_valid;
  logic [31:0] id_pc, id_rD1, id_rD2, id_ext;
  logic [4:0]  id_rR1, id_rR2, id_wR;
  logic        id_rR1_read, id_rR2_read;
  logic        id_is_load, id_is_B, id_is_jal, id_is_jalr;
  logic        id_ram_we, id_alub_sel, id_rf_we;
  logic [2:0]  id_alu_op, id_br_op;
  logic [1:0]  id_rf_wsel;
  logic        ex_redirect;
  logic [31:0] ex_fwd_wD;
  logic        mem_rf_we, wb_rf_we;
  logic [4:0]  mem_wR, wb_wR;
  logic [31:0] mem_wD, wb_wD;
  logic        stall_pc, stall_ifid, flush_ifid;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rD1, ex_rD2, ex_ext;
  logic [4:0]  ex_wR;
  logic        ex_is_load, ex_is_B, ex_is_jal, ex_is_jalr, ex_ram_we;
  logic [2:0]  ex_alu_op, ex_br_op;
  logic        ex_alub_sel, ex_rf_we;
  logic [1:0]  ex_rf_wsel;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int unsigned exp_stall_cnt = 0;
  int unsigned exp_flush_cnt = 0;
`endif

  bundle_t m;
  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .hold(hold), .id_valid(id_valid),
    .id_pc(id_pc), .id_rD1(id_rD1), .id_rD2(id_rD2), .id_ext(id_ext),
    .id_rR1(id_rR1), .id_rR2(id_rR2), .id_wR(id_wR),
    .id_rR1_read(id_rR1_read), .id_rR2_read(id_rR2_read),
    .id_is_load(id_is_load), .id_is_B(id_is_B), .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr),
    .id_ram_we(id_ram_we), .id_alub_sel(id_alub_sel), .id_rf_we(id_rf_we),
    .id_alu_op(id_alu_op), .id_rf_wsel(id_rf_wsel), .id_br_op(id_br_op),
    .ex_redirect(ex_redirect), .ex_fwd_wD(ex_fwd_wD),
    .mem_rf_we(mem_rf_we), .mem_wR(mem_wR), .mem_wD(mem_wD),
    .wb_rf_we(wb_rf_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rD1(ex_rD1), .ex_rD2(ex_rD2), .ex_ext(ex_ext),
    .ex_wR(ex_wR), .ex_is_load(ex_is_load), .ex_is_B(ex_is_B), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_ram_we(ex_ram_we), .ex_alu_op(ex_alu_op),
    .ex_alub_sel(ex_alub_sel), .ex_rf_we(ex_rf_we), .ex_rf_wsel(ex_rf_wsel), .ex_br_op(ex_br_op)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic bundle_t bubble();
    bundle_t b = '0;
    b.br_op = 3'b111;
    return b;
  endfunction

  function automatic bundle_t dut_bundle();
    return {ex_valid, ex_pc, ex_rD1, ex_rD2, ex_ext, ex_wR, ex_is_load, ex_is_B,
            ex_is_jal, ex_is_jalr, ex_ram_we, ex_alu_op, ex_alub_sel, ex_rf_we,
            ex_rf_wsel, ex_br_op};
  endfunction

  // Value an operand must carry into EX, from the bypass rules.
  function automatic logic [31:0] operand(input logic [4:0] rr, input logic rd_used,
                                          input logic [31:0] rf_val);
    if (!rd_used || rr == 5'd0) return rf_val;
    if (m.valid && m.rf_we && !m.is_load && m.wr == rr) return ex_fwd_wD;
    if (mem_rf_we && mem_wR == rr) return mem_wD;
    if (wb_rf_we && wb_wR == rr) return wb_wD;
    return rf_val;
  endfunction

  function automatic logic model_lu();
    return id_valid && m.valid && m.is_load && m.rf_we && m.wr != 5'd0 &&
           ((id_rR1_read && id_rR1 == m.wr) || (id_rR2_read && id_rR2 == m.wr));
  endfunction

  function automatic bundle_t model_next();
    bundle_t n;
    if (hold) return m;
    if (ex_redirect || model_lu() || !id_valid) return bubble();
    n.valid    = 1'b1;
    n.pc       = id_pc;
    n.rd1      = operand(id_rR1, id_rR1_read, id_rD1);
    n.rd2      = operand(id_rR2, id_rR2_read, id_rD2);
    n.ext      = id_ext;
    n.wr       = id_wR;
    n.is_load  = id_is_load;
    n.is_b     = id_is_B;
    n.is_jal   = id_is_jal;
    n.is_jalr  = id_is_jalr;
    n.ram_we   = id_ram_we;
    n.alu_op   = id_alu_op;
    n.alub_sel = id_alub_sel;
    n.rf_we    = id_rf_we;
    n.rf_wsel  = id_rf_wsel;
    n.br_op    = id_br_op;
    return n;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Combinational hazard outputs against the model's view of the current cycle.
  task automatic check_comb();
    logic exp_stall;
    exp_stall = model_lu() && !ex_redirect && !hold;
    check_val("stall_pc", 32'(stall_pc), 32'(exp_stall));
    check_val("stall_ifid", 32'(stall_ifid), 32'(exp_stall));
    check_val("flush_ifid", 32'(flush_ifid), 32'(ex_redirect && !hold));
  endtask

  // Registered EX bundle (and counters when present) against the model.
  task automatic checkOutput();
    bundle_t d;
    d = dut_bundle();
    checks++;
    if (d !== m) begin
      errors++;
      $display("[TB] FAIL ex_bundle actual=%h expected=%h", d, m);
    end
`ifdef HAZARD_PERF_EN
    check_val("perf_stall_cnt", perf_stall_cnt, exp_stall_cnt);
    check_val("perf_flush_cnt", perf_flush_cnt, exp_flush_cnt);
`endif
  endtask

  // One clock: inputs were driven at the preceding negedge.
  task automatic applyStimulus();
    bundle_t nxt;
    #1;
    check_comb();
    nxt = model_next();
`ifdef HAZARD_PERF_EN
    if (!hold) begin
      if (ex_redirect) exp_flush_cnt++;
      else if (model_lu()) exp_stall_cnt++;
    end
`endif
    @(posedge cpu_clk);
    m = nxt;
    #1;
    checkOutput();
    @(negedge cpu_clk);
  endtask

  task automatic set_idle();
    hold = 0; id_valid = 0; id_pc = 0; id_rD1 = 0; id_rD2 = 0; id_ext = 0;
    id_rR1 = 0; id_rR2 = 0; id_wR = 0; id_rR1_read = 0; id_rR2_read = 0;
    id_is_load = 0; id_is_B = 0; id_is_jal = 0; id_is_jalr = 0;
    id_ram_we = 0; id_alub_sel = 0; id_rf_we = 0;
    id_alu_op = 0; id_rf_wsel = 0; id_br_op = 3'b111;
    ex_redirect = 0; ex_fwd_wD = 0;
    mem_rf_we = 0; mem_wR = 0; mem_wD = 0; wb_rf_we = 0; wb_wR = 0; wb_wD = 0;
  endtask

  task automatic set_random();
    hold        = ($urandom_range(0, 7) == 0);
    ex_redirect = ($urandom_range(0, 7) == 0);
    id_valid    = ($urandom_range(0, 3) != 0);
    id_pc = $urandom; id_rD1 = $urandom; id_rD2 = $urandom; id_ext = $urandom;
    id_rR1 = 5'($urandom_range(0, 7)); id_rR2 = 5'($urandom_range(0, 7));
    id_wR  = 5'($urandom_range(0, 7));
    id_rR1_read = 1'($urandom); id_rR2_read = 1'($urandom);
    id_is_load = ($urandom_range(0, 2) == 0);
    id_is_B = 1'($urandom); id_is_jal = 1'($urandom); id_is_jalr = 1'($urandom);
    id_ram_we = 1'($urandom); id_alub_sel = 1'($urandom);
    id_rf_we = ($urandom_range(0, 3) != 0);
    id_alu_op = 3'($urandom); id_rf_wsel = 2'($urandom); id_br_op = 3'($urandom);
    ex_fwd_wD = $urandom;
    mem_rf_we = 1'($urandom); mem_wR = 5'($urandom_range(0, 7)); mem_wD = $urandom;
    wb_rf_we = 1'($urandom); wb_wR = 5'($urandom_range(0, 7)); wb_wD = $urandom;
  endtask

  task automatic load_into_ex(input logic [4:0] rd);
    set_idle();
    id_valid = 1; id_is_load = 1; id_rf_we = 1; id_wR = rd; id_rf_wsel = 2'd1; id_pc = 32'h40;
    applyStimulus();
  endtask

  task automatic dependent_add(input logic [4:0] rs2);
    set_idle();
    id_valid = 1; id_pc = 32'h44; id_rR1 = 5'd3; id_rR1_read = 1; id_rD1 = 32'h3;
    id_rR2 = rs2; id_rR2_read = 1; id_rD2 = 32'h999; id_rf_we = 1; id_wR = 5'd8;
  endtask

  task automatic pulse_reset();
    cpu_rst_n = 0;
    #1;
    m = bubble();
`ifdef HAZARD_PERF_EN
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
`endif
    @(negedge cpu_clk);
    cpu_rst_n = 1;
  endtask

  initial begin
    set_idle();
    m = bubble();
    repeat (2) @(negedge cpu_clk);
    check_val("reset_br_op", 32'(ex_br_op), 32'h7);
    checkOutput();
    cpu_rst_n = 1;

    // Forwarding priority: MEM beats WB; x0 never forwarded.
    set_idle();
    applyStimulus();
    id_valid = 1; id_rR1 = 5'd5; id_rR1_read = 1; id_rD1 = 32'hDEAD;
    mem_rf_we = 1; mem_wR = 5'd5; mem_wD = 32'h11;
    wb_rf_we = 1; wb_wR = 5'd5; wb_wD = 32'h22;
    applyStimulus();
    check_val("fwd_mem_over_wb", ex_rD1, 32'h11);
    id_rR1 = 5'd0;
    mem_wR = 5'd0; wb_wR = 5'd0;
    applyStimulus();
    check_val("fwd_x0_passthru", ex_rD1, 32'hDEAD);

    // Load-use: one stall cycle, one bubble, then capture with MEM data.
    load_into_ex(5'd7);
    dependent_add(5'd7);
    #1;
    check_val("lu_stall_pc", 32'(stall_pc), 32'h1);
    check_val("lu_stall_ifid", 32'(stall_ifid), 32'h1);
    applyStimulus();
    check_val("lu_bubble_rf_we", 32'(ex_rf_we), 32'h0);
    mem_rf_we = 1; mem_wR = 5'd7; mem_wD = 32'h77;
    #1;
    check_val("lu_stall_released", 32'(stall_pc), 32'h0);
    applyStimulus();
    check_val("lu_fwd_rD2", ex_rD2, 32'h77);
    check_val("lu_capture_valid", 32'(ex_valid), 32'h1);

    // Redirect and load-use together: redirect wins.
    load_into_ex(5'd7);
    dependent_add(5'd7);
    ex_redirect = 1;
    #1;
    check_val("redir_flush", 32'(flush_ifid), 32'h1);
    check_val("redir_no_stall", 32'(stall_pc), 32'h0);
    applyStimulus();
    check_val("redir_bubble_valid", 32'(ex_valid), 32'h0);
    check_val("redir_bubble_br_op", 32'(ex_br_op), 32'h7);

    // Hold: three frozen cycles with churning inputs, then a normal capture.
    set_idle();
    id_valid = 1; id_pc = 32'h100; id_rf_we = 1; id_wR = 5'd4;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      set_random();
      hold = 1;
      if (i == 0) ex_redirect = 1;
      #1;
      check_val("hold_stall", 32'(stall_pc), 32'h0);
      check_val("hold_flush", 32'(flush_ifid), 32'h0);
      applyStimulus();
      check_val("hold_ex_pc", ex_pc, 32'h100);
    end
    set_idle();
    id_valid = 1; id_pc = 32'h200;
    applyStimulus();
    check_val("release_ex_pc", ex_pc, 32'h200);

    // Asynchronous reset while EX holds a valid instruction.
    check_val("pre_reset_valid", 32'(ex_valid), 32'h1);
    cpu_rst_n = 0;
    #1;
    check_val("async_rst_valid", 32'(ex_valid), 32'h0);
    check_val("async_rst_pc", ex_pc, 32'h0);
    check_val("async_rst_br_op", 32'(ex_br_op), 32'h7);
    check_val("async_rst_stall", 32'(stall_pc), 32'h0);
    m = bubble();
`ifdef HAZARD_PERF_EN
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
`endif
    checkOutput();
    @(negedge cpu_clk);
    cpu_rst_n = 1;

`ifdef HAZARD_PERF_EN
    // Counters: four load-use stalls then two redirects from a clean reset.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      load_into_ex(5'd9);
      dependent_add(5'd9);
      applyStimulus();
      applyStimulus();
    end
    for (int i = 0; i < 2; i++) begin
      set_idle();
      ex_redirect = 1;
      applyStimulus();
    end
    check_val("perf_stall_four", perf_stall_cnt, 32'd4);
    check_val("perf_flush_two", perf_flush_cnt, 32'd2);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_random();
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
